// File: rtl/adc_bcd_meter.sv
// Block-averaging ADC meter: samples adc_data every SAMPLE_DIV cycles, averages 2^AVG_LOG2
// samples, scales the average to millivolts and converts it to four BCD digits by double-dabble.
module adc_bcd_meter #(
  parameter int SAMPLE_DIV = 48000,
  parameter int AVG_LOG2   = 3,
  parameter int VREF_MV    = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] adc_data,
  input  logic       hold,
  output logic [7:0] avg_out,
  output logic [3:0] num1,
  output logic [3:0] num2,
  output logic [3:0] num3,
  output logic [3:0] num4,
  output logic       upd
);

  localparam int CNT_W = $clog2(SAMPLE_DIV);
  localparam int SMP_W = AVG_LOG2 + 1;
  localparam int ACC_W = 8 + AVG_LOG2;
  localparam int NSAMP = 1 << AVG_LOG2;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [SMP_W-1:0] SMP_LAST  = SMP_W'(NSAMP - 1);
  localparam logic [13:0]      VREF      = 14'(VREF_MV);
  localparam logic [3:0]       ITER_LAST = 4'd13;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LOAD
  } state_t;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SMP_W-1:0] smp_q, smp_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] full_sum;
  logic             tick;
  logic [7:0]       avg_q, avg_d;
  logic             avg_vld_q, avg_vld_d;
  logic [21:0]      prod_q, prod_d;
  logic             prod_vld_q, prod_vld_d;
  logic [13:0]      mv;

  state_t           state_q, state_d;
  logic [3:0]       iter_q, iter_d;
  logic [13:0]      bin_q, bin_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [15:0]      dig_q, dig_d;
  logic             upd_q, upd_d;

  // One double-dabble iteration: add 3 to every nibble >= 5, then shift {bcd, bin} left by one.
  function automatic logic [29:0] dd_step(input logic [15:0] bcd_v, input logic [13:0] bin_v);
    logic [15:0] adj;
    adj = bcd_v;
    for (int i = 0; i < 4; i++) begin
      if (bcd_v[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_v[4*i +: 4] + 4'd3;
    end
    return 30'({adj, bin_v} << 1);
  endfunction

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    tick       = (cnt_q == CNT_LAST);
    full_sum   = acc_q + ACC_W'(adc_data);
    cnt_d      = tick ? '0 : cnt_q + CNT_W'(1);
    smp_d      = smp_q;
    acc_d      = acc_q;
    avg_d      = avg_q;
    avg_vld_d  = 1'b0;
    if (tick) begin
      if (smp_q == SMP_LAST) begin
        smp_d     = '0;
        acc_d     = '0;
        avg_d     = 8'(full_sum >> AVG_LOG2);
        avg_vld_d = 1'b1;
      end else begin
        smp_d = smp_q + SMP_W'(1);
        acc_d = full_sum;
      end
    end
    prod_d     = avg_vld_q ? 22'(avg_q) * 22'(VREF) : prod_q;
    prod_vld_d = avg_vld_q;
  end

  assign mv = 14'(prod_q >> 8);

  // The first shift is folded into the IDLE->CONV transition so LOAD lands 16 cycles after the block.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    dig_d   = dig_q;
    upd_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (prod_vld_q) begin
          {bcd_d, bin_d} = dd_step(16'd0, mv);
          iter_d         = 4'd1;
          state_d        = CONV;
        end
      end
      CONV: begin
        {bcd_d, bin_d} = dd_step(bcd_q, bin_q);
        iter_d         = iter_q + 4'd1;
        if (iter_q == ITER_LAST) state_d = LOAD;
      end
      LOAD: begin
        state_d = IDLE;
        if (!hold) begin
          dig_d = bcd_q;
          upd_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      smp_q      <= '0;
      acc_q      <= '0;
      avg_q      <= '0;
      avg_vld_q  <= 1'b0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      state_q    <= IDLE;
      iter_q     <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      dig_q      <= '0;
      upd_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      smp_q      <= smp_d;
      acc_q      <= acc_d;
      avg_q      <= avg_d;
      avg_vld_q  <= avg_vld_d;
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      state_q    <= state_d;
      iter_q     <= iter_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      dig_q      <= dig_d;
      upd_q      <= upd_d;
    end
  end

  assign avg_out = avg_q;
  assign num1    = dig_q[3:0];
  assign num2    = dig_q[7:4];
  assign num3    = dig_q[11:8];
  assign num4    = dig_q[15:12];
  assign upd     = upd_q;

endmodule

// File: tb/tb_adc_bcd_meter.sv
// Directed bench for adc_bcd_meter: main instance at defaults with SAMPLE_DIV=32, plus
// two corner instances (AVG_LOG2=0/VREF_MV=9999 and VREF_MV=1) fed a constant full-scale code.
module tb_adc_bcd_meter;

  localparam int SD = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst_c, hold;
  logic [7:0] adc_data;
  logic [7:0] avg_out, a0_avg, v1_avg;
  logic [3:0] num1, num2, num3, num4;
  logic [3:0] a0_n1, a0_n2, a0_n3, a0_n4;
  logic [3:0] v1_n1, v1_n2, v1_n3, v1_n4;
  logic       upd, a0_upd, v1_upd;

  int cyc;
  int n_assert = 0;
  int n_fail   = 0;
  int upd_cnt = 0, a0_upd_cnt = 0, v1_upd_cnt = 0;
  int last_upd_cyc = 0, a0_last_upd_cyc = 0;

  adc_bcd_meter #(.SAMPLE_DIV(SD), .AVG_LOG2(3), .VREF_MV(5000)) dut (
    .clk(clk), .rst(rst), .adc_data(adc_data), .hold(hold), .avg_out(avg_out),
    .num1(num1), .num2(num2), .num3(num3), .num4(num4), .upd(upd)
  );

  adc_bcd_meter #(.SAMPLE_DIV(SD), .AVG_LOG2(0), .VREF_MV(9999)) dut_a0 (
    .clk(clk), .rst(rst_c), .adc_data(8'hFF), .hold(1'b0), .avg_out(a0_avg),
    .num1(a0_n1), .num2(a0_n2), .num3(a0_n3), .num4(a0_n4), .upd(a0_upd)
  );

  adc_bcd_meter #(.SAMPLE_DIV(SD), .AVG_LOG2(3), .VREF_MV(1)) dut_v1 (
    .clk(clk), .rst(rst_c), .adc_data(8'hFF), .hold(1'b0), .avg_out(v1_avg),
    .num1(v1_n1), .num2(v1_n2), .num3(v1_n3), .num4(v1_n4), .upd(v1_upd)
  );

  // Cycle index relative to the last edge that saw rst high; tick captures land on multiples of SD.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (upd === 1'b1) begin
      upd_cnt      <= upd_cnt + 1;
      last_upd_cyc <= cyc;
    end
    if (a0_upd === 1'b1) begin
      a0_upd_cnt      <= a0_upd_cnt + 1;
      a0_last_upd_cyc <= cyc;
    end
    if (v1_upd === 1'b1) v1_upd_cnt <= v1_upd_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Present v and advance to just after the next tick capture edge.
  task automatic feed(input logic [7:0] v);
    adc_data = v;
    do step(); while (cyc % SD != 0);
  endtask

  // From just after final-sample edge s, wait (bounded) for upd, then check latency, digits, pulse width.
  task automatic wait_upd(input string tag, input int s, input logic [15:0] exp_dig);
    int n;
    n = 0;
    while (upd !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check({tag, "_lat"}, cyc - s, 16);
    check({tag, "_dig"}, {num4, num3, num2, num1}, exp_dig);
    step();
    check({tag, "_pulse"}, upd, 0);
  endtask

  initial begin
    int s, u0, t0;
    rst      = 1'b1;
    rst_c    = 1'b1;
    hold     = 1'b0;
    adc_data = 8'h00;
    repeat (3) @(posedge clk);
    step();
    rst   = 1'b0;
    rst_c = 1'b0;

    check("rst_avg", avg_out, 0);
    check("rst_dig", {num4, num3, num2, num1}, 0);
    check("rst_upd", upd, 0);

    // Full scale: 4980 mV
    for (int i = 0; i < 7; i++) feed(8'hFF);
    check("fs_avg_early", avg_out, 0);
    feed(8'hFF);
    s = cyc;
    check("fs_avg", avg_out, 255);
    wait_upd("fs", s, 16'h4980);

    // Corner instances, sampled at the same moment (cyc 273)
    check("a0_dig", {a0_n4, a0_n3, a0_n2, a0_n1}, 16'h9959);
    check("a0_avg", a0_avg, 255);
    check("a0_upd_every_tick", a0_upd_cnt, 8);
    check("a0_last_upd", a0_last_upd_cyc, 272);
    check("v1_dig", {v1_n4, v1_n3, v1_n2, v1_n1}, 16'h0000);
    check("v1_avg", v1_avg, 255);
    check("v1_upd_cnt", v1_upd_cnt, 1);

    // Averaging with truncation: (4*128 + 4*129)/8 = 128.5 -> 128 -> 2500 mV
    for (int i = 0; i < 4; i++) feed(8'h80);
    for (int i = 0; i < 3; i++) feed(8'h81);
    check("avg_prev_held", avg_out, 255);
    feed(8'h81);
    s = cyc;
    check("avg_128", avg_out, 128);
    wait_upd("avg128", s, 16'h2500);

    // 7/8 truncates to zero
    for (int i = 0; i < 7; i++) feed(8'h00);
    feed(8'h07);
    s = cyc;
    check("trunc_avg", avg_out, 0);
    wait_upd("trunc", s, 16'h0000);

    // Known result, then a held block of zeros
    for (int i = 0; i < 8; i++) feed(8'h80);
    s = cyc;
    wait_upd("known", s, 16'h2500);
    hold = 1'b1;
    u0   = upd_cnt;
    for (int i = 0; i < 8; i++) feed(8'h00);
    check("hold_avg", avg_out, 0);
    repeat (20) step();
    check("hold_no_upd", upd_cnt, u0);
    check("hold_dig", {num4, num3, num2, num1}, 16'h2500);
    hold = 1'b0;
    repeat (8) step();
    check("release_no_reload", upd_cnt, u0);
    check("release_dig", {num4, num3, num2, num1}, 16'h2500);
    for (int i = 0; i < 8; i++) feed(8'h00);
    s = cyc;
    wait_upd("release", s, 16'h0000);

    // Reset pulse at S+5 aborts the conversion in flight
    for (int i = 0; i < 8; i++) feed(8'hFF);
    s = cyc;
    wait_upd("pre_rst", s, 16'h4980);
    for (int i = 0; i < 8; i++) feed(8'h80);
    s = cyc;
    check("rst_blk_avg", avg_out, 128);
    u0 = upd_cnt;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_avg", avg_out, 0);
    check("mid_rst_dig", {num4, num3, num2, num1}, 16'h0000);
    check("mid_rst_upd", upd, 0);
    repeat (30) step();
    check("mid_rst_no_upd", upd_cnt, u0);
    for (int i = 0; i < 7; i++) feed(8'h40);
    check("fresh_no_early_upd", upd_cnt, u0);
    check("fresh_avg_early", avg_out, 0);
    feed(8'h40);
    s = cyc;
    check("fresh_avg", avg_out, 64);
    wait_upd("fresh", s, 16'h1250);

    // Ramp across block boundaries, then cadence over four consecutive blocks
    for (int i = 0; i < 8; i++) feed(8'(i));
    s = cyc;
    check("ramp_lo_avg", avg_out, 3);
    wait_upd("ramp_lo", s, 16'h0058);
    t0 = last_upd_cyc;
    for (int i = 8; i < 16; i++) feed(8'(i));
    s = cyc;
    check("ramp_hi_avg", avg_out, 11);
    wait_upd("ramp_hi", s, 16'h0214);
    check("cadence_1", last_upd_cyc - t0, 256);
    t0 = last_upd_cyc;
    for (int i = 0; i < 8; i++) feed(8'h33);
    s = cyc;
    wait_upd("blk_51", s, 16'h0996);
    check("cadence_2", last_upd_cyc - t0, 256);
    t0 = last_upd_cyc;
    for (int i = 0; i < 8; i++) feed(8'hC0);
    s = cyc;
    check("blk_192_avg", avg_out, 192);
    wait_upd("blk_192", s, 16'h3750);
    check("cadence_3", last_upd_cyc - t0, 256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
